// File: rtl/rot_pkg.sv
// Shared types and helpers for the pipelined barrel rotator/shifter.
package rot_pkg;

  typedef enum logic [1:0] {
    ROT_R = 2'b00,
    ROT_L = 2'b01,
    SHR_L = 2'b10,
    SHR_A = 2'b11
  } rot_op_t;

  // Cycles from input acceptance to out_valid for a given width and register spacing.
  function automatic int rot_lat(input int width, input int reg_every);
    int levels;
    levels = $clog2(width);
    return (levels + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/rot_shift_pipe_if.sv
// Valid/ready handshake bundle for rot_shift_pipe: input side and result side.
interface rot_shift_pipe_if
  import rot_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int L = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [L-1:0]     in_amt;
  rot_op_t          in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rot_level.sv
// One combinational mux level of the barrel rotator: rotate right by 2**K when selected.
module rot_level #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int S = 1 << K;

  // Conditional fixed-distance right rotate.
  always_comb begin
    data_o = data_i;
    if (sel_i) begin
      data_o = {data_i[S-1:0], data_i[WIDTH-1:S]};
    end else begin
      data_o = data_i;
    end
  end
endmodule

// File: rtl/rot_shift_pipe.sv
// Pipelined barrel rotator/shifter: rotate right/left and logical/arithmetic right shift,
// with a global-enable valid/ready pipeline carrying an opaque tag.
module rot_shift_pipe
  import rot_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  rot_shift_pipe_if.slave io
);
  localparam int L = $clog2(WIDTH);

  // ramt steers the rotate core; amt and fill are kept for the final shift mask.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
    logic [L-1:0]     ramt;
    logic [L-1:0]     amt;
    logic             shift;
    logic             fill;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t entry_s;
  stage_t bnd_s [L+1];
  logic   en_s;

  assign en_s        = !bnd_s[L].vld || io.out_ready;
  assign io.in_ready = en_s;

  // Entry normalisation: left rotates become right rotates by (WIDTH - amt) mod WIDTH.
  always_comb begin
    entry_s       = '0;
    entry_s.vld   = io.in_valid;
    entry_s.data  = io.in_data;
    entry_s.amt   = io.in_amt;
    entry_s.tag   = io.in_tag;
    entry_s.shift = (io.in_op == SHR_L) || (io.in_op == SHR_A);
    entry_s.fill  = (io.in_op == SHR_A) && io.in_data[WIDTH-1];
    if (io.in_op == ROT_L) begin
      entry_s.ramt = {L{1'b0}} - io.in_amt;
    end else begin
      entry_s.ramt = io.in_amt;
    end
  end

  assign bnd_s[0] = entry_s;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam bit LAST     = (k == L - 1);
    localparam bit REG_HERE = LAST || (((k + 1) % REG_EVERY) == 0);

    logic [WIDTH-1:0] rot_s;
    logic [WIDTH-1:0] keep_s;
    stage_t           lvl_d;

    rot_level #(.WIDTH(WIDTH), .K(k)) u_level (
      .data_i (bnd_s[k].data),
      .sel_i  (bnd_s[k].ramt[k]),
      .data_o (rot_s)
    );

    // Level result; the last level replaces the top amt bits with the shift fill.
    always_comb begin
      lvl_d  = bnd_s[k];
      keep_s = {WIDTH{1'b1}} >> bnd_s[k].amt;
      if (LAST && bnd_s[k].shift) begin
        lvl_d.data = (rot_s & keep_s) | ({WIDTH{bnd_s[k].fill}} & ~keep_s);
      end else begin
        lvl_d.data = rot_s;
      end
    end

    if (REG_HERE) begin : g_reg
      stage_t lvl_q;

      // Stage register; every stage holds together when the output is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lvl_q <= '0;
        end else if (en_s) begin
          lvl_q <= lvl_d;
        end
      end

      assign bnd_s[k+1] = lvl_q;
    end else begin : g_comb
      assign bnd_s[k+1] = lvl_d;
    end
  end

  assign io.out_valid = bnd_s[L].vld;
  assign io.out_data  = bnd_s[L].data;
  assign io.out_tag   = bnd_s[L].tag;
endmodule

// File: tb/tb_rot_shift_pipe.sv
// Scoreboard bench: a 32-bit/5-stage instance with directed vectors, stall and reset
// scenarios, and an 8-bit/1-stage instance swept exhaustively against a reference model.
module tb_rot_shift_pipe;
  import rot_pkg::*;

  localparam int WA = 32;
  localparam int RA = 1;
  localparam int WB = 8;
  localparam int RB = 3;
  localparam int TW = 4;
  localparam int LAT_A = 5;
  localparam int LAT_B = 1;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            acc;
    bit            chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rot_shift_pipe_if #(.WIDTH(WA), .TAG_W(TW)) ia ();
  rot_shift_pipe_if #(.WIDTH(WB), .TAG_W(TW)) ib ();

  rot_shift_pipe #(.WIDTH(WA), .REG_EVERY(RA), .TAG_W(TW)) u_a (
    .clk(clk), .rst_n(rst_n), .io(ia.slave));
  rot_shift_pipe #(.WIDTH(WB), .REG_EVERY(RB), .TAG_W(TW)) u_b (
    .clk(clk), .rst_n(rst_n), .io(ib.slave));

  function automatic logic [7:0] ref8(input logic [7:0] d, input int a, input rot_op_t op);
    logic [7:0] r;
    case (op)
      ROT_R:   r = (d >> a) | (d << (8 - a));
      ROT_L:   r = (d << a) | (d >> (8 - a));
      SHR_L:   r = d >> a;
      default: r = $signed(d) >>> a;
    endcase
    return r;
  endfunction

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      n_cmp++;
      if (ia.in_ready !== (!ia.out_valid || ia.out_ready)) begin
        n_fail++;
        $display("FAIL a_in_ready cyc=%0d got=%b want=%b", cyc, ia.in_ready, !ia.out_valid || ia.out_ready);
      end
      if (ia.out_valid && ia.out_ready) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected cyc=%0d got data=%h tag=%h want no output", cyc, ia.out_data, ia.out_tag);
        end else begin
          e = qa.pop_front();
          if (ia.out_data !== e.data || ia.out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL a_result cyc=%0d got data=%h tag=%h want data=%h tag=%h",
                     cyc, ia.out_data, ia.out_tag, e.data, e.tag);
          end
          if (e.chk) begin
            n_cmp++;
            if (cyc - e.acc != LAT_A) begin
              n_fail++;
              $display("FAIL a_latency tag=%h got=%0d want=%0d", e.tag, cyc - e.acc, LAT_A);
            end
          end
        end
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && ib.out_valid && ib.out_ready) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected cyc=%0d got data=%h want no output", cyc, ib.out_data);
      end else begin
        e = qb.pop_front();
        if (ib.out_data !== e.data[7:0] || ib.out_tag !== e.tag || cyc - e.acc != LAT_B) begin
          n_fail++;
          $display("FAIL b_result cyc=%0d got data=%h tag=%h lat=%0d want data=%h tag=%h lat=%0d",
                   cyc, ib.out_data, ib.out_tag, cyc - e.acc, e.data[7:0], e.tag, LAT_B);
        end
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [4:0] amt, input rot_op_t op,
                        input logic [TW-1:0] tag, input logic [31:0] want, input bit chk);
    int budget;
    exp_t e;
    budget = 0;
    ia.in_valid = 1'b1; ia.in_data = d; ia.in_amt = amt; ia.in_op = op; ia.in_tag = tag;
    forever begin
      @(negedge clk);
      if (ia.in_ready) break;
      budget++;
      if (budget > 200) break;
    end
    if (ia.in_ready) begin
      e.data = want; e.tag = tag; e.acc = cyc; e.chk = chk;
      qa.push_back(e);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL a_accept_timeout tag=%h got in_ready=0 want 1", tag);
    end
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [2:0] amt, input rot_op_t op,
                        input logic [TW-1:0] tag, input logic [7:0] want);
    exp_t e;
    ib.in_valid = 1'b1; ib.in_data = d; ib.in_amt = amt; ib.in_op = op; ib.in_tag = tag;
    @(negedge clk);
    if (ib.in_ready) begin
      e.data = {24'h000000, want}; e.tag = tag; e.acc = cyc; e.chk = 1'b1;
      qb.push_back(e);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL b_in_ready cyc=%0d got=0 want=1", cyc);
    end
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
  endtask

  task automatic drain(input bit which_b);
    int budget;
    budget = 0;
    while ((which_b ? qb.size() : qa.size()) != 0 && budget < 40 * rot_lat(WA, RA)) begin
      @(posedge clk); #1;
      budget++;
    end
    n_cmp++;
    if ((which_b ? qb.size() : qa.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_%s got %0d outstanding want 0", which_b ? "b" : "a",
               which_b ? qb.size() : qa.size());
    end
  endtask

  initial begin
    int budget;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_amt = '0; ia.in_op = ROT_R; ia.in_tag = '0;
    ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_amt = '0; ib.in_op = ROT_R; ib.in_tag = '0;
    ib.out_ready = 1'b1;
    #2;
    n_cmp += 4;
    if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", ia.out_valid); end
    if (ia.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h want=0", ia.out_data); end
    if (ia.out_tag !== 4'h0) begin n_fail++; $display("FAIL rst_out_tag got=%h want=0", ia.out_tag); end
    if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", ia.in_ready); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    send_a(32'h0000007F, 5'd7,  ROT_R, 4'h1, 32'hFE000000, 1'b1);
    send_a(32'h00000080, 5'd7,  ROT_R, 4'h2, 32'h00000001, 1'b1);
    send_a(32'h80000001, 5'd1,  ROT_L, 4'h3, 32'h00000003, 1'b1);
    send_a(32'hDEADBEEF, 5'd0,  ROT_L, 4'h4, 32'hDEADBEEF, 1'b1);
    send_a(32'h80000000, 5'd4,  SHR_L, 4'h5, 32'h08000000, 1'b1);
    send_a(32'h80000000, 5'd4,  SHR_A, 4'h6, 32'hF8000000, 1'b1);
    send_a(32'h7FFFFFFF, 5'd31, SHR_A, 4'h7, 32'h00000000, 1'b1);
    send_a(32'h80000000, 5'd31, SHR_A, 4'h8, 32'hFFFFFFFF, 1'b1);
    send_a(32'h00000001, 5'd31, ROT_R, 4'h9, 32'h00000002, 1'b1);
    send_a(32'hFFFFFFFF, 5'd31, SHR_L, 4'hA, 32'h00000001, 1'b1);
    send_a(32'h12345678, 5'd8,  ROT_L, 4'hB, 32'h34567812, 1'b1);
    send_a(32'hDEADBEEF, 5'd0,  SHR_A, 4'hC, 32'hDEADBEEF, 1'b1);
    drain(1'b0);

    // Back-to-back stream of 8 with a 4-cycle output stall.
    fork
      begin
        send_a(32'h00000100, 5'd0, ROT_R, 4'h0, 32'h00000100, 1'b0);
        send_a(32'h00000100, 5'd1, ROT_R, 4'h1, 32'h00000080, 1'b0);
        send_a(32'h00000100, 5'd2, ROT_R, 4'h2, 32'h00000040, 1'b0);
        send_a(32'h00000100, 5'd3, ROT_R, 4'h3, 32'h00000020, 1'b0);
        send_a(32'h00000100, 5'd4, ROT_R, 4'h4, 32'h00000010, 1'b0);
        send_a(32'h00000100, 5'd5, ROT_R, 4'h5, 32'h00000008, 1'b0);
        send_a(32'h00000100, 5'd6, ROT_R, 4'h6, 32'h00000004, 1'b0);
        send_a(32'h00000100, 5'd7, ROT_R, 4'h7, 32'h00000002, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ia.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 ia.out_ready = 1'b1;
      end
    join
    drain(1'b0);

    // Reset with three words in flight, the oldest parked at the stalled output.
    send_a(32'h00000001, 5'd1, ROT_R, 4'hD, 32'h80000000, 1'b0);
    send_a(32'h00000002, 5'd1, ROT_R, 4'hE, 32'h00000001, 1'b0);
    send_a(32'h00000004, 5'd1, ROT_R, 4'hF, 32'h00000002, 1'b0);
    ia.out_ready = 1'b0;
    budget = 0;
    while (!ia.out_valid && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", ia.out_valid); end
    if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", ia.in_ready); end
    qa.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ia.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send_a(32'h80000000, 5'd8, SHR_A, 4'h9, 32'hFF800000, 1'b1);
    drain(1'b0);

    // Exhaustive 8-bit sweep at full throughput.
    for (int d = 0; d < 256; d++) begin
      for (int a = 0; a < 8; a++) begin
        for (int o = 0; o < 4; o++) begin
          send_b(d[7:0], a[2:0], rot_op_t'(o[1:0]), 4'(d + a + o),
                 ref8(d[7:0], a, rot_op_t'(o[1:0])));
        end
      end
    end
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
